demux3_stream: RTL and testbench

DEMUX3_STREAM -- requirements
Module: demux3_stream

---
 rtl/demux3_pkg.sv | 19 +
 rtl/demux3_slot.sv | 43 ++++
 rtl/demux3_stream.sv | 94 +++++++++
 tb/tb_demux3_stream.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux3_pkg.sv
// Shared types and constants for the 1-to-3 stream demultiplexer.
package demux3_pkg;

  typedef enum logic [1:0] {
    DEST0    = 2'b00,
    DEST1    = 2'b01,
    DEST2    = 2'b10,
    DEST_INV = 2'b11
  } dest_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_st_e;

  localparam int NUM_PORTS  = 3;
  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/demux3_slot.sv
// One-entry output slot: holds a beat until its consumer takes it.
module demux3_slot
  import demux3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             out_ready,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  slot_st_e st;

  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= EMPTY;
      q  <= '0;
    end else begin
      unique case (st)
        EMPTY: begin
          if (load) begin
            st <= FULL;
            q  <= data;
          end
        end
        FULL: begin
          if (load) begin
            q <= data;
          end else if (out_ready) begin
            st <= EMPTY;
          end
        end
      endcase
    end
  end

  assign valid = (st == FULL);

endmodule

// File: rtl/demux3_stream.sv
// 1-to-3 valid/ready stream demux with per-port one-entry slots.
// Optional saturating drop counter enabled by DEMUX3_DROP_CNT_EN.
module demux3_stream
  import demux3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
`ifdef DEMUX3_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
  output logic             sel_err
);

  dest_e                  sel;
  logic                   accept;
  logic [NUM_PORTS-1:0]   load;
  logic [NUM_PORTS-1:0]   full;
  logic [WIDTH-1:0]       q [NUM_PORTS];

  assign sel    = dest_e'(in_sel);
  assign accept = in_valid && in_ready;

  // Ready depends only on the addressed slot, so a stalled port never blocks others.
  always_comb begin
    in_ready = 1'b0;
    if (reset) begin
      unique case (sel)
        DEST0:    in_ready = !full[0] || out_ready[0];
        DEST1:    in_ready = !full[1] || out_ready[1];
        DEST2:    in_ready = !full[2] || out_ready[2];
        DEST_INV: in_ready = 1'b1;
      endcase
    end
  end

  always_comb begin
    load = '0;
    if (accept) begin
      unique case (sel)
        DEST0:    load[0] = 1'b1;
        DEST1:    load[1] = 1'b1;
        DEST2:    load[2] = 1'b1;
        DEST_INV: load = '0;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
    demux3_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[i]),
      .data      (in_data),
      .out_ready (out_ready[i]),
      .valid     (full[i]),
      .q         (q[i])
    );
  end

  assign out_valid = full;
  assign out_data0 = q[0];
  assign out_data1 = q[1];
  assign out_data2 = q[2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= accept && (sel == DEST_INV);
    end
  end

`ifdef DEMUX3_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (accept && (sel == DEST_INV) && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux3_stream.sv
// Directed self-checking bench for demux3_stream.
`timescale 1ns/1ps
module tb_demux3_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic [2:0] out_valid;
  logic [2:0] out_ready;
  logic [7:0] out_data0;
  logic [7:0] out_data1;
  logic [7:0] out_data2;
  logic       sel_err;
`ifdef DEMUX3_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux3_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
`ifdef DEMUX3_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .sel_err   (sel_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0;
    in_sel = 2'b00; out_ready = 3'b111;
    tick();
    tick();
    checks++;
    if (out_valid !== 3'b000) begin
      failures++;
      $display("FAIL rst_valid got=%b exp=000", out_valid);
    end
    checks++;
    if ({out_data0, out_data1, out_data2} !== 24'h0) begin
      failures++;
      $display("FAIL rst_data got=%h %h %h exp=0", out_data0, out_data1, out_data2);
    end
    checks++;
    if (sel_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_sel_err got=%b exp=0", sel_err);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_ready got=%b exp=0", in_ready);
    end
`ifdef DEMUX3_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_routing();
    logic [7:0] d   [3] = '{8'd6, 8'd8, 8'd2};
    logic [2:0] ev  [3] = '{3'b001, 3'b010, 3'b100};
    logic [7:0] got;
    out_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = d[i]; in_sel = 2'(i);
      tick();
      got = (i == 0) ? out_data0 : (i == 1) ? out_data1 : out_data2;
      checks++;
      if (out_valid !== ev[i]) begin
        failures++;
        $display("FAIL route_valid%0d got=%b exp=%b", i, out_valid, ev[i]);
      end
      checks++;
      if (got !== d[i]) begin
        failures++;
        $display("FAIL route_data%0d got=%0d exp=%0d", i, got, d[i]);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 3'b000) begin
      failures++;
      $display("FAIL route_drain got=%b exp=000", out_valid);
    end
  endtask

  task automatic test_invalid();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd5; in_sel = 2'b11;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL inv_ready got=%b exp=1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 3'b000) begin
      failures++;
      $display("FAIL inv_valid got=%b exp=000", out_valid);
    end
    checks++;
    if (sel_err !== 1'b1) begin
      failures++;
      $display("FAIL inv_sel_err got=%b exp=1", sel_err);
    end
`ifdef DEMUX3_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin
      failures++;
      $display("FAIL inv_drop_cnt got=%0d exp=1", drop_cnt);
    end
`endif
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    checks++;
    if (sel_err !== 1'b0) begin
      failures++;
      $display("FAIL inv_sel_err_clr got=%b exp=0", sel_err);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 3'b101;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd8; in_sel = 2'b01;
    tick();
    checks++;
    if (out_valid[1] !== 1'b1 || out_data1 !== 8'd8) begin
      failures++;
      $display("FAIL bp_first got=%b/%0d exp=1/8", out_valid[1], out_data1);
    end
    @(negedge clk);
    in_data = 8'd9;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_lo got=%b exp=0", in_ready);
    end
    tick();
    checks++;
    if (out_data1 !== 8'd8) begin
      failures++;
      $display("FAIL bp_hold got=%0d exp=8", out_data1);
    end
    @(negedge clk);
    out_ready = 3'b111;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_hi got=%b exp=1", in_ready);
    end
    tick();
    checks++;
    if (out_valid[1] !== 1'b1 || out_data1 !== 8'd9) begin
      failures++;
      $display("FAIL bp_second got=%b/%0d exp=1/9", out_valid[1], out_data1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 3'b000) begin
      failures++;
      $display("FAIL bp_drain got=%b exp=000", out_valid);
    end
  endtask

  task automatic test_independence();
    out_ready = 3'b000;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd7; in_sel = 2'b00;
    tick();
    @(negedge clk);
    in_data = 8'd3; in_sel = 2'b10;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ind_ready got=%b exp=1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 3'b101) begin
      failures++;
      $display("FAIL ind_valid got=%b exp=101", out_valid);
    end
    checks++;
    if (out_data2 !== 8'd3 || out_data0 !== 8'd7) begin
      failures++;
      $display("FAIL ind_data got=%0d/%0d exp=3/7", out_data2, out_data0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 3'b111;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(i + 1); in_sel = 2'(i);
    end
    tick();
    checks++;
    if (out_valid !== 3'b111) begin
      failures++;
      $display("FAIL mid_full got=%b exp=111", out_valid);
    end
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'b11; reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_ready got=%b exp=0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 3'b000) begin
      failures++;
      $display("FAIL mid_valid got=%b exp=000", out_valid);
    end
    checks++;
    if ({out_data0, out_data1, out_data2} !== 24'h0) begin
      failures++;
      $display("FAIL mid_data got=%h %h %h exp=0", out_data0, out_data1, out_data2);
    end
    checks++;
    if (sel_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_sel_err got=%b exp=0", sel_err);
    end
`ifdef DEMUX3_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL mid_drop_cnt got=%0d exp=0", drop_cnt);
    end
`endif
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1; out_ready = 3'b111;
    tick();
  endtask

`ifdef DEMUX3_DROP_CNT_EN
  task automatic test_saturation();
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'b11; in_data = 8'hAA;
    for (int i = 0; i < 260; i++) begin
      tick();
      checks++;
      if (sel_err !== 1'b1) begin
        failures++;
        $display("FAIL sat_sel_err%0d got=%b exp=1", i, sel_err);
      end
    end
    checks++;
    if (drop_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_drop_cnt got=%0d exp=255", drop_cnt);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_invalid();
    test_backpressure();
    test_independence();
    test_reset_mid();
`ifdef DEMUX3_DROP_CNT_EN
    test_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
